multi_draw: RTL and testbench
=============================

MULTI_DRAW -- requirements
Module: multi_draw

Interface
REQ-001 Parameter N_OBJ, default 8, meaning number of rectangle objects in the table (2..32).
REQ-002 Parameter W, default 10, meaning width of every coordinate and size field.
REQ-003 Derived width IW = max(1, clog2(N_OBJ)), used for object indices.
REQ-004 Clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 Reset_n  input  1  reset, asynchronous and active-low.
REQ-006 wr_en  input  1  write one object entry into the shadow table.
REQ-007 wr_idx  input  IW  index of the object to write.
REQ-008 wr_x, wr_y  input  W each  top-left corner of the object.
REQ-009 wr_sx, wr_sy  input  W each  object width and height in pixels.
REQ-010 wr_vis  input  1  object visible flag.
REQ-011 commit  input  1  one-cycle strobe (frame sync); copies the whole shadow table into the active table.
REQ-012 pix_valid  input  1  DrawX/DrawY carry a pixel to test.
REQ-013 DrawX, DrawY  input  W each  pixel coordinate under test.
REQ-014 out_valid  output  1  hit results for one pixel are valid.
REQ-015 hit  output  1  the pixel lies inside at least one visible active object.
REQ-016 hit_idx  output  IW  lowest index of the objects hit; 0 when hit=0.
REQ-017 hit_mask  output  N_OBJ  bit i set when object i is hit.

Function
REQ-018 The shadow and active tables SHALL each hold N_OBJ entries of {x, y, sx, sy, vis}.
REQ-019 When wr_en=1 and wr_idx<N_OBJ, the shadow entry wr_idx SHALL be loaded on that edge; wr_idx>=N_OBJ SHALL be ignored.
REQ-020 The pixel test SHALL use only the active table; shadow writes SHALL have no effect on the results until a commit.
REQ-021 When commit=1, the active table SHALL take the shadow contents as they were before that edge; a write on the same edge lands in the shadow table only.
REQ-022 Object i SHALL hit when vis=1 and X<=DrawX<X+sx and Y<=DrawY<Y+sy, with each sum computed in W+1 bits (no wrap-around).
REQ-023 A size of sx=0 or sy=0 SHALL never hit; an object extending past 2^W-1 SHALL be clipped and not wrapped.
REQ-024 Stage 1: on a valid pixel, all N_OBJ comparisons SHALL be registered into a hit-vector register, together with a stage-1 valid bit.
REQ-025 Stage 2: the stage-1 vector SHALL be priority-encoded (lowest index wins) and registered into hit, hit_idx, hit_mask, and out_valid.
REQ-026 Latency SHALL be exactly 2 cycles from pix_valid to out_valid, at a throughput of one pixel per cycle, with no stalls.
REQ-027 The pipeline SHALL accept a new pixel every cycle without a handshake; when pix_valid=0 a bubble SHALL propagate and out_valid SHALL be 0 two cycles later.
REQ-028 A commit SHALL affect pixels sampled on the edge after the commit edge; pixels already in flight SHALL keep their stage-1 results.
REQ-029 While out_valid=0, hit, hit_idx, and hit_mask SHALL hold their last values.

Reset
REQ-030 Reset_n=0 SHALL asynchronously clear both tables (all fields 0, vis=0), the stage valids, out_valid, hit, hit_idx, and hit_mask.
REQ-031 Deasserting reset mid-stream SHALL discard in-flight pixels; the first out_valid SHALL follow the first pix_valid after reset by 2 cycles.
REQ-032 After reset and before any commit, every pixel SHALL report hit=0.

Verification
REQ-033 Write object 0 {x=100, y=50, sx=20, sy=10, vis=1}, commit, then pixels (100,50), (119,59), (120,59), (99,50) -> hit 1,1,0,0 with hit_idx 0, each out_valid 2 cycles after its pix_valid.
REQ-034 Objects 2 and 5 overlap at (300,200) and both are committed -> hit_mask=0b00100100, hit_idx=2; clear vis on 2 and commit -> hit_idx=5.
REQ-035 Write object 1 with no commit, then test a pixel inside it -> hit=0; assert commit and wr_en together on the same edge -> the old shadow contents are committed and the new write stays pending.
REQ-036 W=10, object {x=1020, sx=10}, DrawX=2 -> hit=0 (no wrap); DrawX=1023 -> hit=1.
REQ-037 Stream pix_valid=1 for 8 cycles with a commit in cycle 4 -> 8 back-to-back out_valid; pixels 0-3 use the old table and pixels 4-7 use the new table.
REQ-038 Pull Reset_n low for 1 cycle mid-stream -> out_valid=0 and both tables clear immediately; after release, no hits occur until a new write and commit.

Source files
------------

// File: rtl/multi_draw.sv
// Multi-object rectangle hit tester: double-buffered object table (shadow/active)
// and a two-stage pixel pipeline (compare, then priority encode).
module multi_draw #(
  parameter int N_OBJ = 8,
  parameter int W     = 10,
  localparam int IW   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [W-1:0]     wr_x,
  input  logic [W-1:0]     wr_y,
  input  logic [W-1:0]     wr_sx,
  input  logic [W-1:0]     wr_sy,
  input  logic             wr_vis,
  input  logic             commit,
  input  logic             pix_valid,
  input  logic [W-1:0]     DrawX,
  input  logic [W-1:0]     DrawY,
  output logic             out_valid,
  output logic             hit,
  output logic [IW-1:0]    hit_idx,
  output logic [N_OBJ-1:0] hit_mask
);

  logic [W-1:0]     sh_x   [N_OBJ];
  logic [W-1:0]     sh_y   [N_OBJ];
  logic [W-1:0]     sh_sx  [N_OBJ];
  logic [W-1:0]     sh_sy  [N_OBJ];
  logic [N_OBJ-1:0] sh_vis;

  logic [W-1:0]     act_x  [N_OBJ];
  logic [W-1:0]     act_y  [N_OBJ];
  logic [W-1:0]     act_sx [N_OBJ];
  logic [W-1:0]     act_sy [N_OBJ];
  logic [N_OBJ-1:0] act_vis;

  logic [31:0]      wr_idx_ext;
  logic             wr_ok;

  logic [N_OBJ-1:0] hit_vec;
  logic             s1_valid;
  logic [N_OBJ-1:0] s1_vec;
  logic [IW-1:0]    enc_idx;

  // Widened index so the range check stays meaningful for non power-of-two N_OBJ.
  assign wr_idx_ext = 32'(wr_idx);
  assign wr_ok      = wr_en && (wr_idx_ext < 32'(N_OBJ));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        sh_sx[i] <= '0;
        sh_sy[i] <= '0;
      end
      sh_vis <= '0;
    end else if (wr_ok) begin
      sh_x[wr_idx]   <= wr_x;
      sh_y[wr_idx]   <= wr_y;
      sh_sx[wr_idx]  <= wr_sx;
      sh_sy[wr_idx]  <= wr_sy;
      sh_vis[wr_idx] <= wr_vis;
    end
  end

  // Commit copies the pre-edge shadow, so a same-edge write stays pending.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        act_x[i]  <= '0;
        act_y[i]  <= '0;
        act_sx[i] <= '0;
        act_sy[i] <= '0;
      end
      act_vis <= '0;
    end else if (commit) begin
      act_x   <= sh_x;
      act_y   <= sh_y;
      act_sx  <= sh_sx;
      act_sy  <= sh_sy;
      act_vis <= sh_vis;
    end
  end

  // End of span computed one bit wider so objects near the edge clip instead of wrapping.
  function automatic logic in_span(input logic [W-1:0] p, input logic [W-1:0] lo,
                                   input logic [W-1:0] len);
    logic [W:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (p >= lo) && ({1'b0, p} < hi);
  endfunction

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_vec[i] = act_vis[i] && in_span(DrawX, act_x[i], act_sx[i])
                              && in_span(DrawY, act_y[i], act_sy[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_vec <= hit_vec;
      end
    end
  end

  always_comb begin
    enc_idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (s1_vec[i]) begin
        enc_idx = IW'(i);
      end
    end
  end

  // Result registers only move on a valid stage-1 entry; bubbles leave them untouched.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      hit_mask  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        hit      <= |s1_vec;
        hit_idx  <= enc_idx;
        hit_mask <= s1_vec;
      end
    end
  end

endmodule

// File: tb/tb_multi_draw.sv
// Self-checking bench for multi_draw: directed vectors, multi-cycle corner
// sequences and randomized traffic against a behavioural table/pipeline model.
module tb_multi_draw;
  localparam int N  = 8;
  localparam int W  = 10;
  localparam int IW = 3;

  logic           Clk, Reset_n;
  logic           wr_en, wr_vis, commit, pix_valid;
  logic [IW-1:0]  wr_idx;
  logic [W-1:0]   wr_x, wr_y, wr_sx, wr_sy, DrawX, DrawY;
  logic           out_valid, hit;
  logic [IW-1:0]  hit_idx;
  logic [N-1:0]   hit_mask;

  multi_draw #(.N_OBJ(N), .W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_sx(wr_sx), .wr_sy(wr_sy), .wr_vis(wr_vis),
    .commit(commit), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .out_valid(out_valid), .hit(hit), .hit_idx(hit_idx), .hit_mask(hit_mask)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model
  typedef struct { int x; int y; int sx; int sy; bit vis; } obj_t;
  obj_t m_sh[N];
  obj_t m_act[N];
  bit   m_s1_v;
  int   m_s1_mask;
  bit   m_ov, m_hit;
  int   m_idx, m_mask;

  function automatic int model_mask(input int dx, input int dy);
    int m = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i].vis && dx >= m_act[i].x && dx < m_act[i].x + m_act[i].sx &&
          dy >= m_act[i].y && dy < m_act[i].y + m_act[i].sy)
        m |= (1 << i);
    end
    return m;
  endfunction

  function automatic int lowest(input int m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 1'b0};
      m_act[i] = '{0, 0, 0, 0, 1'b0};
    end
    m_s1_v = 0; m_s1_mask = 0;
    m_ov = 0; m_hit = 0; m_idx = 0; m_mask = 0;
  endtask

  // Advance model with the currently driven inputs, clock the DUT, compare.
  task automatic clk_step();
    int nm;
    nm = model_mask(int'(DrawX), int'(DrawY));
    m_ov = m_s1_v;
    if (m_s1_v) begin
      m_mask = m_s1_mask;
      m_hit  = (m_s1_mask != 0);
      m_idx  = lowest(m_s1_mask);
    end
    m_s1_v = pix_valid;
    if (pix_valid) m_s1_mask = nm;
    if (commit) m_act = m_sh;
    if (wr_en && int'(wr_idx) < N)
      m_sh[wr_idx] = '{int'(wr_x), int'(wr_y), int'(wr_sx), int'(wr_sy), wr_vis};
    @(posedge Clk); #1;
    chk("model_out_valid", int'(out_valid), int'(m_ov));
    chk("model_hit",       int'(hit),       int'(m_hit));
    chk("model_hit_idx",   int'(hit_idx),   m_idx);
    chk("model_hit_mask",  int'(hit_mask),  m_mask);
  endtask

  task automatic idle_inputs();
    wr_en = 0; commit = 0; pix_valid = 0;
  endtask

  task automatic write_obj(input int idx, input int x, input int y, input int sx,
                           input int sy, input bit vis, input bit with_commit);
    wr_en = 1; wr_idx = IW'(idx); wr_x = W'(x); wr_y = W'(y);
    wr_sx = W'(sx); wr_sy = W'(sy); wr_vis = vis; commit = with_commit;
    clk_step();
    idle_inputs();
  endtask

  task automatic do_commit();
    commit = 1;
    clk_step();
    commit = 0;
  endtask

  // Single pixel, checked against constants at exactly 2-cycle latency.
  task automatic probe(input string name, input int dx, input int dy,
                       input int eh, input int ei, input int em);
    pix_valid = 1; DrawX = W'(dx); DrawY = W'(dy);
    clk_step();
    pix_valid = 0;
    chk({name, "_lat1_valid"}, int'(out_valid), 0);
    clk_step();
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_hit"},   int'(hit),       eh);
    chk({name, "_idx"},   int'(hit_idx),   ei);
    chk({name, "_mask"},  int'(hit_mask),  em);
  endtask

  typedef struct { int dx; int dy; int eh; int ei; int em; } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{100, 50, 1, 0, 1};
    vecs[1] = '{119, 59, 1, 0, 1};
    vecs[2] = '{120, 59, 0, 0, 0};
    vecs[3] = '{99,  50, 0, 0, 0};

    Reset_n = 0; idle_inputs();
    wr_idx = '0; wr_x = '0; wr_y = '0; wr_sx = '0; wr_sy = '0; wr_vis = 0;
    DrawX = '0; DrawY = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_hit",       int'(hit),       0);
    chk("rst_hit_idx",   int'(hit_idx),   0);
    chk("rst_hit_mask",  int'(hit_mask),  0);
    Reset_n = 1;

    probe("pre_commit_origin", 0, 0, 0, 0, 0);

    // Basic containment and edges of object 0
    write_obj(0, 100, 50, 20, 10, 1, 0);
    do_commit();
    for (int i = 0; i < 4; i++)
      probe($sformatf("vec%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].eh, vecs[i].ei, vecs[i].em);

    // Overlap priority
    write_obj(2, 290, 190, 20, 20, 1, 0);
    write_obj(5, 295, 195, 10, 10, 1, 0);
    do_commit();
    probe("overlap", 300, 200, 1, 2, 8'h24);
    write_obj(2, 290, 190, 20, 20, 0, 0);
    do_commit();
    probe("overlap_vis_off", 300, 200, 1, 5, 8'h20);

    // Shadow isolation and commit/write on the same edge
    write_obj(1, 400, 400, 10, 10, 1, 0);
    probe("shadow_only", 405, 405, 0, 0, 0);
    write_obj(1, 600, 600, 10, 10, 1, 1);
    probe("old_committed", 405, 405, 1, 1, 8'h02);
    probe("new_pending", 605, 605, 0, 0, 0);
    do_commit();
    probe("new_committed", 605, 605, 1, 1, 8'h02);
    probe("old_gone", 405, 405, 0, 0, 0);

    // Right-edge clipping
    write_obj(3, 1020, 0, 10, 10, 1, 0);
    do_commit();
    probe("no_wrap", 2, 0, 0, 0, 0);
    probe("clip_edge", 1023, 0, 1, 3, 8'h08);

    // Back-to-back stream with commit alongside pixel 3
    write_obj(1, 700, 700, 10, 10, 1, 0);
    for (int k = 0; k <= 8; k++) begin
      pix_valid = (k < 8); DrawX = W'(605); DrawY = W'(605);
      commit = (k == 3);
      clk_step();
      if (k >= 1) begin
        chk($sformatf("stream%0d_valid", k - 1), int'(out_valid), 1);
        chk($sformatf("stream%0d_hit", k - 1), int'(hit), (k - 1 < 4) ? 1 : 0);
      end
    end
    idle_inputs();
    clk_step();
    chk("stream_bubble", int'(out_valid), 0);
    chk("stream_hold_hit", int'(hit), 0);

    // Mid-stream reset
    write_obj(4, 600, 600, 10, 10, 1, 1);
    do_commit();
    pix_valid = 1; DrawX = W'(605); DrawY = W'(605);
    clk_step();
    clk_step();
    chk("pre_rst_hit", int'(hit), 1);
    Reset_n = 0;
    #2;
    model_reset();
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_hit",   int'(hit),       0);
    chk("async_rst_mask",  int'(hit_mask),  0);
    @(posedge Clk); #1;
    Reset_n = 1;
    clk_step();
    chk("post_rst_lat1", int'(out_valid), 0);
    clk_step();
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_no_hit", int'(hit), 0);
    idle_inputs();
    clk_step();
    write_obj(4, 600, 600, 10, 10, 1, 0);
    do_commit();
    probe("post_rst_rewrite", 605, 605, 1, 4, 8'h10);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int j, dx, dy;
      wr_en  = ($urandom_range(0, 2) == 0);
      wr_idx = IW'($urandom_range(0, N - 1));
      wr_x   = W'($urandom_range(0, 1023));
      wr_y   = W'($urandom_range(0, 1023));
      wr_sx  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 250));
      wr_sy  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 250));
      wr_vis = ($urandom_range(0, 3) != 0);
      commit = ($urandom_range(0, 5) == 0);
      pix_valid = ($urandom_range(0, 3) != 0);
      j  = $urandom_range(0, N - 1);
      dx = m_act[j].x + $urandom_range(0, 260) - 5;
      dy = m_act[j].y + $urandom_range(0, 260) - 5;
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
      if (dy < 0) dy = 0;
      if (dy > 1023) dy = 1023;
      DrawX = W'(dx); DrawY = W'(dy);
      clk_step();
    end
    idle_inputs();
    clk_step();
    clk_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
